wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 86 ++++++++
 rtl/wb_writer.sv | 151 +++++++++++++++
 tb/tb_wb_writer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back writer and its load-return queue.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    // One queued load return; kill marks an entry overtaken by a younger ALU write.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-return queue: circular buffer with registered occupancy and a
// kill-by-rd port that marks every valid entry targeting a given register.
// With WB_HAZARD_EN defined, the entries and their valid mask are exported
// for hazard comparison.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [REG_AW-1:0]        push_rd_i,
    input  logic [XLEN-1:0]          push_data_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    input  logic                     kill_en_i,
    input  logic [REG_AW-1:0]        kill_rd_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
`ifdef WB_HAZARD_EN
    ,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [DEPTH-1:0] valid;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign valid[gi] = ({1'b0, (PW'(gi) - rd_ptr_q)} < count_q);
    end

`ifdef WB_HAZARD_EN
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_export
        assign entries_o[gi] = mem_q[gi];
    end
    assign valid_o = valid;
`endif

    // Storage, pointers and occupancy; kills touch only entries already queued,
    // so a same-cycle push always lands with its kill bit clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en_i && valid[i] && (mem_q[i].rd == kill_rd_i)) begin
                    mem_q[i].kill <= 1'b1;
                end
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wb_entry_t'{rd: push_rd_i, data: push_data_i, kill: 1'b0};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back writer: merges an unstallable ALU result stream with queued load
// returns into one registered register-file write port. ALU wins each cycle;
// a starvation counter forces a one-cycle ALU stall so the queue head drains.
// Optional macro WB_HAZARD_EN enables the rs1/rs2 read-after-write hazard flags.
module wb_writer
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_valid_i,
    input  logic [REG_AW-1:0]      alu_rd_i,
    input  logic [XLEN-1:0]        alu_data_i,
    output logic                   alu_stall_o,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    input  logic [REG_AW-1:0]      ld_rd_i,
    input  logic [XLEN-1:0]        ld_data_i,
    output logic                   RegWrite_o,
    output logic [REG_AW-1:0]      RDaddr_o,
    output logic [XLEN-1:0]        RDdata_o,
    input  logic [REG_AW-1:0]      RS1addr_i,
    input  logic [REG_AW-1:0]      RS2addr_i,
    output logic                   rs1_pending_o,
    output logic                   rs2_pending_o,
    output logic [$clog2(DEPTH):0] q_count_o
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    wb_entry_t         head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              kill_en;

    logic              we_q,   we_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [SW-1:0]     cnt_q,  cnt_d;
    logic              stall_q, stall_d;

`ifdef WB_HAZARD_EN
    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;
`endif

    assign ld_ready_o = !full;
    assign push       = ld_valid_i && ld_ready_o;
    assign kill_en    = alu_valid_i && (alu_rd_i != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_rd_i   (ld_rd_i),
        .push_data_i (ld_data_i),
        .pop_i       (pop),
        .head_o      (head),
        .kill_en_i   (kill_en),
        .kill_rd_i   (alu_rd_i),
        .count_o     (q_count_o),
        .full_o      (full),
        .empty_o     (empty)
`ifdef WB_HAZARD_EN
        ,
        .entries_o   (entries),
        .valid_o     (valid)
`endif
    );

    // Source selection: ALU first, else queue head; rd 0 and killed entries write nothing.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        pop    = 1'b0;
        if (alu_valid_i) begin
            if (alu_rd_i != '0) begin
                we_d   = 1'b1;
                addr_d = alu_rd_i;
                data_d = alu_data_i;
            end
        end else if (!empty) begin
            pop = 1'b1;
            if ((head.rd != '0) && !head.kill) begin
                we_d   = 1'b1;
                addr_d = head.rd;
                data_d = head.data;
            end
        end
    end

    // Starvation: count consecutive ALU wins over a waiting load, stall once at the limit.
    always_comb begin
        cnt_d   = '0;
        stall_d = 1'b0;
        if (alu_valid_i && !empty) begin
            if (cnt_q == SW'(STARVE_MAX - 1)) begin
                stall_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Registered write port and starvation state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign RegWrite_o  = we_q;
    assign RDaddr_o    = addr_q;
    assign RDdata_o    = data_q;
    assign alu_stall_o = stall_q;

`ifdef WB_HAZARD_EN
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    // A source register is pending while a live, unkilled entry or the output register targets it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
        assign hit1[gi] = valid[gi] && !entries[gi].kill && (entries[gi].rd == RS1addr_i);
        assign hit2[gi] = valid[gi] && !entries[gi].kill && (entries[gi].rd == RS2addr_i);
    end

    assign rs1_pending_o = (RS1addr_i != '0) && ((|hit1) || (we_q && (addr_q == RS1addr_i)));
    assign rs2_pending_o = (RS2addr_i != '0) && ((|hit2) || (we_q && (addr_q == RS2addr_i)));
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^{RS1addr_i, RS2addr_i};
    assign rs1_pending_o  = 1'b0;
    assign rs2_pending_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: directed scenarios plus randomized traffic
// against a queue-based reference model of the write-back rules.
module tb_wb_writer;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [63:0] alu_data_i;
    logic        alu_stall_o;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [63:0] ld_data_i;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [63:0] RDdata_o;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic        rs1_pending_o;
    logic        rs2_pending_o;
    logic [2:0]  q_count_o;

    wb_writer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_stall_o   (alu_stall_o),
        .ld_valid_i    (ld_valid_i),
        .ld_ready_o    (ld_ready_o),
        .ld_rd_i       (ld_rd_i),
        .ld_data_i     (ld_data_i),
        .RegWrite_o    (RegWrite_o),
        .RDaddr_o      (RDaddr_o),
        .RDdata_o      (RDdata_o),
        .RS1addr_i     (RS1addr_i),
        .RS2addr_i     (RS2addr_i),
        .rs1_pending_o (rs1_pending_o),
        .rs2_pending_o (rs2_pending_o),
        .q_count_o     (q_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: pending loads in arrival order, plus expected port state.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        bit          kill;
    } ent_t;

    ent_t        mq[$];
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    bit          exp_stall;
    int          run_len;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic bit exp_pending(input logic [4:0] rs);
`ifdef WB_HAZARD_EN
        if (rs == 5'd0) return 1'b0;
        if (exp_we && exp_addr == rs) return 1'b1;
        foreach (mq[i]) if (!mq[i].kill && mq[i].rd == rs) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_stall = 1'b0;
        run_len   = 0;
    endfunction

    // Drive one cycle of stimulus, advance through the clock edge, update the model.
    task automatic cycle(input bit av, input logic [4:0] ar, input logic [63:0] ad,
                         input bit lv, input logic [4:0] lr, input logic [63:0] ld);
        bit   push;
        bit   had;
        ent_t h;
        alu_valid_i = av;
        alu_rd_i    = ar;
        alu_data_i  = ad;
        ld_valid_i  = lv;
        ld_rd_i     = lr;
        ld_data_i   = ld;
        push = lv && (mq.size() < DEPTH);
        @(posedge clk_i);
        had = (mq.size() != 0);
        if (av && had) begin
            run_len++;
            exp_stall = (run_len == STARVE_MAX);
            if (exp_stall) run_len = 0;
        end else begin
            run_len   = 0;
            exp_stall = 1'b0;
        end
        if (av) begin
            exp_we = (ar != 5'd0);
            if (exp_we) begin
                foreach (mq[i]) if (mq[i].rd == ar) mq[i].kill = 1'b1;
                exp_addr = ar;
                exp_data = ad;
            end
        end else if (had) begin
            h = mq.pop_front();
            exp_we = (h.rd != 5'd0) && !h.kill;
            if (exp_we) begin
                exp_addr = h.rd;
                exp_data = h.data;
            end
        end else begin
            exp_we = 1'b0;
        end
        if (push) mq.push_back('{lr, ld, 1'b0});
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_reset();
        n_checks++; if (RegWrite_o !== 1'b0) $display("FAIL reset_we got=%0b exp=0", RegWrite_o); else n_pass++;
        n_checks++; if (RDaddr_o !== 5'd0) $display("FAIL reset_addr got=%0d exp=0", RDaddr_o); else n_pass++;
        n_checks++; if (RDdata_o !== 64'd0) $display("FAIL reset_data got=%0h exp=0", RDdata_o); else n_pass++;
        n_checks++; if (alu_stall_o !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", alu_stall_o); else n_pass++;
        n_checks++; if (q_count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", q_count_o); else n_pass++;
        n_checks++; if (ld_ready_o !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", ld_ready_o); else n_pass++;
        n_checks++; if (rs1_pending_o !== 1'b0 || rs2_pending_o !== 1'b0)
            $display("FAIL reset_pending got=%0b%0b exp=00", rs1_pending_o, rs2_pending_o); else n_pass++;
        $display("reset: checks=%0d", n_checks);
    endtask

    task automatic test_alu_only();
        cycle(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd5 || RDdata_o !== 64'h1234)
            $display("FAIL alu_only got we=%0b rd=%0d d=%0h exp we=1 rd=5 d=1234", RegWrite_o, RDaddr_o, RDdata_o); else n_pass++;
        idle();
        n_checks++; if (RegWrite_o !== 1'b0 || RDaddr_o !== 5'd5 || RDdata_o !== 64'h1234)
            $display("FAIL alu_hold got we=%0b rd=%0d d=%0h exp we=0 rd=5 d=1234", RegWrite_o, RDaddr_o, RDdata_o); else n_pass++;
        $display("alu_only: rd=5 data=1234");
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 5'd3, 64'hAAAA, 1'b1, 5'd7, 64'h7777);
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd3 || q_count_o !== 3'd1)
            $display("FAIL same_c1 got we=%0b rd=%0d cnt=%0d exp we=1 rd=3 cnt=1", RegWrite_o, RDaddr_o, q_count_o); else n_pass++;
        idle();
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd7 || RDdata_o !== 64'h7777 || q_count_o !== 3'd0)
            $display("FAIL same_c2 got we=%0b rd=%0d d=%0h cnt=%0d exp we=1 rd=7 d=7777 cnt=0",
                     RegWrite_o, RDaddr_o, RDdata_o, q_count_o); else n_pass++;
        $display("same_cycle: alu rd=3 then load rd=7");
    endtask

    task automatic test_starve();
        for (int c = 1; c <= 9; c++) begin
            cycle(1'b1, 5'(16 + $urandom_range(0, 15)), {$urandom(), $urandom()},
                  (c <= 4), 5'(7 + c), {$urandom(), $urandom()});
            if (c == 4) begin
                n_checks++; if (ld_ready_o !== 1'b0 || q_count_o !== 3'd4)
                    $display("FAIL starve_full got ready=%0b cnt=%0d exp ready=0 cnt=4", ld_ready_o, q_count_o); else n_pass++;
            end
            n_checks++; if (alu_stall_o !== exp_stall)
                $display("FAIL starve_stall c=%0d got=%0b exp=%0b", c, alu_stall_o, exp_stall); else n_pass++;
        end
        n_checks++; if (alu_stall_o !== 1'b1)
            $display("FAIL starve_pulse got=%0b exp=1", alu_stall_o); else n_pass++;
        // Stall cycle honoured: head load (rd 8) drains.
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd8 || RDdata_o !== exp_data || q_count_o !== 3'd3 || alu_stall_o !== 1'b0)
            $display("FAIL starve_head got we=%0b rd=%0d d=%0h cnt=%0d stall=%0b exp we=1 rd=8 d=%0h cnt=3 stall=0",
                     RegWrite_o, RDaddr_o, RDdata_o, q_count_o, alu_stall_o, exp_data); else n_pass++;
        // Build a second stall, then keep the ALU valid through it.
        for (int c = 0; c < STARVE_MAX; c++) begin
            cycle(1'b1, 5'(16 + $urandom_range(0, 15)), {$urandom(), $urandom()}, 1'b0, 5'd0, 64'd0);
        end
        n_checks++; if (alu_stall_o !== 1'b1)
            $display("FAIL starve_pulse2 got=%0b exp=1", alu_stall_o); else n_pass++;
        cycle(1'b1, 5'd20, 64'hBEEF, 1'b0, 5'd0, 64'd0);
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd20 || RDdata_o !== 64'hBEEF || q_count_o !== 3'd3)
            $display("FAIL stall_alu_wins got we=%0b rd=%0d d=%0h cnt=%0d exp we=1 rd=20 d=beef cnt=3",
                     RegWrite_o, RDaddr_o, RDdata_o, q_count_o); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            idle();
            n_checks++; if (RegWrite_o !== exp_we || RDaddr_o !== exp_addr || RDdata_o !== exp_data || q_count_o !== 3'(mq.size()))
                $display("FAIL starve_drain got we=%0b rd=%0d cnt=%0d exp we=%0b rd=%0d cnt=%0d",
                         RegWrite_o, RDaddr_o, q_count_o, exp_we, exp_addr, mq.size()); else n_pass++;
        end
        $display("starve: stall pulses observed, queue drained");
    endtask

    task automatic test_kill();
        cycle(1'b1, 5'd2, 64'h22, 1'b1, 5'd9, 64'h9999);
        cycle(1'b1, 5'd9, 64'hA9, 1'b0, 5'd0, 64'd0);
        n_checks++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd9 || RDdata_o !== 64'hA9 || q_count_o !== 3'd1)
            $display("FAIL kill_alu got we=%0b rd=%0d d=%0h cnt=%0d exp we=1 rd=9 d=a9 cnt=1",
                     RegWrite_o, RDaddr_o, RDdata_o, q_count_o); else n_pass++;
        idle();
        n_checks++; if (RegWrite_o !== 1'b0 || RDaddr_o !== 5'd9 || RDdata_o !== 64'hA9 || q_count_o !== 3'd0)
            $display("FAIL kill_pop got we=%0b rd=%0d d=%0h cnt=%0d exp we=0 rd=9 d=a9 cnt=0",
                     RegWrite_o, RDaddr_o, RDdata_o, q_count_o); else n_pass++;
        $display("kill: stale load rd=9 suppressed");
    endtask

    task automatic test_rd0();
        cycle(1'b1, 5'd0, 64'h1, 1'b1, 5'd0, 64'h2);
        n_checks++; if (RegWrite_o !== 1'b0 || q_count_o !== 3'd1)
            $display("FAIL rd0_alu got we=%0b cnt=%0d exp we=0 cnt=1", RegWrite_o, q_count_o); else n_pass++;
        idle();
        n_checks++; if (RegWrite_o !== 1'b0 || q_count_o !== 3'd0 || RDaddr_o !== 5'd9)
            $display("FAIL rd0_drain got we=%0b cnt=%0d rd=%0d exp we=0 cnt=0 rd=9", RegWrite_o, q_count_o, RDaddr_o); else n_pass++;
        $display("rd0: both sources dropped");
    endtask

    task automatic test_random();
        int  errs_before;
        bit  av;
        errs_before = n_checks - n_pass;
        for (int c = 0; c < 400; c++) begin
            av = exp_stall ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            RS1addr_i = 5'($urandom_range(0, 7));
            RS2addr_i = 5'($urandom_range(0, 7));
            cycle(av, 5'($urandom_range(0, 7)), {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom(), $urandom()});
            n_checks++; if (RegWrite_o !== exp_we || RDaddr_o !== exp_addr || RDdata_o !== exp_data)
                $display("FAIL rand_port c=%0d got we=%0b rd=%0d d=%0h exp we=%0b rd=%0d d=%0h",
                         c, RegWrite_o, RDaddr_o, RDdata_o, exp_we, exp_addr, exp_data); else n_pass++;
            n_checks++; if (q_count_o !== 3'(mq.size()) || ld_ready_o !== (mq.size() < DEPTH))
                $display("FAIL rand_queue c=%0d got cnt=%0d ready=%0b exp cnt=%0d", c, q_count_o, ld_ready_o, mq.size()); else n_pass++;
            n_checks++; if (alu_stall_o !== exp_stall)
                $display("FAIL rand_stall c=%0d got=%0b exp=%0b", c, alu_stall_o, exp_stall); else n_pass++;
            n_checks++; if (rs1_pending_o !== exp_pending(RS1addr_i) || rs2_pending_o !== exp_pending(RS2addr_i))
                $display("FAIL rand_pending c=%0d got=%0b%0b exp=%0b%0b", c, rs1_pending_o, rs2_pending_o,
                         exp_pending(RS1addr_i), exp_pending(RS2addr_i)); else n_pass++;
        end
        RS1addr_i = 5'd0;
        RS2addr_i = 5'd0;
        for (int c = 0; c < DEPTH; c++) idle();
        $display("random: 400 cycles, new failures=%0d", (n_checks - n_pass) - errs_before);
    endtask

    task automatic test_reset_mid();
        RS1addr_i = 5'd4;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 5'(20 + c), {$urandom(), $urandom()}, 1'b1, 5'(4 + c), {$urandom(), $urandom()});
        end
        n_checks++; if (q_count_o !== 3'd3)
            $display("FAIL mid_fill got cnt=%0d exp=3", q_count_o); else n_pass++;
        n_checks++; if (rs1_pending_o !== exp_pending(5'd4))
            $display("FAIL mid_hazard got=%0b exp=%0b", rs1_pending_o, exp_pending(5'd4)); else n_pass++;
        rst_i = 1'b0;
        #1;
        model_reset();
        n_checks++; if (q_count_o !== 3'd0 || RegWrite_o !== 1'b0 || ld_ready_o !== 1'b1 || rs1_pending_o !== 1'b0 || RDaddr_o !== 5'd0)
            $display("FAIL mid_reset got cnt=%0d we=%0b ready=%0b pend=%0b rd=%0d exp cnt=0 we=0 ready=1 pend=0 rd=0",
                     q_count_o, RegWrite_o, ld_ready_o, rs1_pending_o, RDaddr_o); else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle();
            n_checks++; if (RegWrite_o !== 1'b0 || q_count_o !== 3'd0)
                $display("FAIL mid_after got we=%0b cnt=%0d exp we=0 cnt=0", RegWrite_o, q_count_o); else n_pass++;
        end
        RS1addr_i = 5'd0;
        $display("reset_mid: queue discarded");
    endtask

    initial begin
        rst_i       = 1'b0;
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
        RS1addr_i   = '0;
        RS2addr_i   = '0;
        model_reset();
        #1;
        test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        test_alu_only();
        test_same_cycle();
        test_starve();
        test_kill();
        test_rd0();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
